// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port 32x8 data RAM between the CPU (port 0)
// and the loader (port 1); each transaction runs IDLE -> ACCESS -> RESP.
module ram_arbiter #(
    parameter int DEPTH = 32,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    // Handshake: a requester raises reqN with weN/addrN/wdataN and holds them stable
    // until doneN; gntN pulses for the single cycle the command drives the RAM, and
    // doneN (with errN/rdataN valid) pulses the cycle after. There is no backpressure.
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    dbgState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    localparam logic [AW:0] DepthW = DEPTH[AW:0];

    stateT         state;
    stateT         stateNext;
    logic          last;
    logic          winId;
    logic          cmdWe;
    logic [AW-1:0] cmdAddr;
    logic [DW-1:0] cmdWdata;
    logic          oor;

    logic          anyReq;
    logic          pick;
    logic          selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;
    logic [DW-1:0] capData;

    assign anyReq = req0 | req1;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    assign selWe    = pick ? we1    : we0;
    assign selAddr  = pick ? addr1  : addr0;
    assign selWdata = pick ? wdata1 : wdata0;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= 1'b1;
            winId    <= 1'b0;
            cmdWe    <= 1'b0;
            cmdAddr  <= '0;
            cmdWdata <= '0;
            oor      <= 1'b0;
        end else if (state == IDLE && anyReq) begin
            last     <= pick;
            winId    <= pick;
            cmdWe    <= selWe;
            cmdAddr  <= selAddr;
            cmdWdata <= selWdata;
            oor      <= ({1'b0, selAddr} >= DepthW);
        end
    end

    // Writes and blocked accesses return zero rather than whatever the RAM presents.
    assign capData = (cmdWe || oor) ? '0 : ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS) begin
            if (winId) begin
                rdata1 <= capData;
            end else begin
                rdata0 <= capData;
            end
        end
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ACCESS: begin
                gnt0      = ~winId;
                gnt1      = winId;
                ram_we    = cmdWe & ~oor;
                ram_re    = ~cmdWe & ~oor;
                ram_addr  = cmdAddr;
                ram_wdata = cmdWdata;
            end
            RESP: begin
                done0 = ~winId;
                done1 = winId;
                err0  = ~winId & oor;
                err1  = winId & oor;
            end
            default: ;
        endcase
    end

    assign dbgState = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single transactions plus hand-written
// sequences for reset mid-access, command latching and round-robin alternation.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, done0, err0, gnt1, done1, err1;
    logic [7:0] rdata0, rdata1;
    logic       ram_we, ram_re;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0] dbgState;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];
    logic [7:0] lastRd [2];
    logic [7:0] exp_q [$];

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] expRd;
        logic       expErr;
    } vecT;

    vecT vecs [11];

    always #5 clk = ~clk;

    ram_arbiter #(.DEPTH(32), .AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbgState(dbgState)
    );

    // RAM model: combinational read, write on the rising edge.
    assign ram_rdata = (ram_addr < 8'd32) ? mem[ram_addr[4:0]] : 8'h00;
    always @(posedge clk) begin
        if (ram_we && ram_addr < 8'd32) mem[ram_addr[4:0]] <= ram_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drivePort(input int port, input logic r, input logic w,
                             input logic [7:0] a, input logic [7:0] d);
        if (port == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic doTxn(input int port, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] expRd,
                         input logic expErr, input logic chgAddr, input string tag);
        logic       gotGnt;
        int         lat;
        logic [7:0] expPop;
        gotGnt = 1'b0;
        lat    = 99;
        exp_q.push_back(expRd);
        @(negedge clk);
        drivePort(port, 1'b1, w, a, d);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ((port == 0) ? gnt0 : gnt1) begin
                gotGnt = 1'b1;
                lat    = i;
                break;
            end
        end
        check({tag, " gnt seen"}, gotGnt, 1);
        check({tag, " gnt latency"}, lat, 0);
        check({tag, " other gnt"}, (port == 0) ? gnt1 : gnt0, 0);
        check({tag, " ram_addr"}, ram_addr, a);
        check({tag, " ram_we"}, ram_we, w && (a < 8'd32));
        check({tag, " ram_re"}, ram_re, !w && (a < 8'd32));
        if (chgAddr) drivePort(port, 1'b1, w, 8'd9, d);
        @(negedge clk);
        expPop = exp_q.pop_front();
        check({tag, " done"}, (port == 0) ? done0 : done1, 1);
        check({tag, " err"}, (port == 0) ? err0 : err1, expErr);
        check({tag, " rdata"}, (port == 0) ? rdata0 : rdata1, expPop);
        check({tag, " other rdata"}, (port == 0) ? rdata1 : rdata0, lastRd[1 - port]);
        check({tag, " ram_we resp"}, ram_we, 0);
        lastRd[port] = expPop;
        drivePort(port, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    function automatic logic [63:0] allOuts();
        return {gnt0, done0, err0, rdata0, gnt1, done1, err1, rdata1,
                ram_we, ram_re, ram_addr, ram_wdata};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic sawDone;
        int   gCycle [$];
        int   gId [$];
        for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
        mem[10] = 8'h3C;
        mem[11] = 8'h11;
        lastRd[0] = 8'h00;
        lastRd[1] = 8'h00;
        drivePort(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);

        vecs[0]  = '{0, 1'b1, 8'd3,   8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{0, 1'b0, 8'd3,   8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1, 1'b1, 8'd32,  8'h7F, 8'h00, 1'b1};
        vecs[3]  = '{1, 1'b0, 8'd31,  8'h00, 8'h5F, 1'b0};
        vecs[4]  = '{1, 1'b0, 8'd10,  8'h00, 8'h3C, 1'b0};
        vecs[5]  = '{0, 1'b0, 8'd11,  8'h00, 8'h11, 1'b0};
        vecs[6]  = '{1, 1'b1, 8'd255, 8'h12, 8'h00, 1'b1};
        vecs[7]  = '{0, 1'b1, 8'd31,  8'hE1, 8'h00, 1'b0};
        vecs[8]  = '{1, 1'b0, 8'd31,  8'h00, 8'hE1, 1'b0};
        vecs[9]  = '{1, 1'b0, 8'd32,  8'h00, 8'h00, 1'b1};
        vecs[10] = '{0, 1'b0, 8'd3,   8'h00, 8'hA5, 1'b0};

        // Power-on reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset outputs", allOuts(), 0);
        check("reset state", dbgState, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset outputs", allOuts(), 0);

        // Reset asserted while a port 0 write to addr 5 is in ACCESS
        @(negedge clk);
        drivePort(0, 1'b1, 1'b1, 8'd5, 8'hEE);
        @(negedge clk);
        check("mid gnt0", gnt0, 1);
        check("mid ram_we", ram_we, 1);
        #1 reset = 1'b1;
        #1;
        check("mid reset outputs", allOuts(), 0);
        check("mid reset state", dbgState, 0);
        drivePort(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        lastRd[0] = 8'h00;
        lastRd[1] = 8'h00;
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done0 || done1) sawDone = 1'b1;
        end
        check("no done after reset", sawDone, 0);
        doTxn(0, 1'b0, 8'd5, 8'h00, 8'h45, 1'b0, 1'b0, "addr5 pre-write");

        for (int v = 0; v < 11; v++) begin
            doTxn(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                  vecs[v].expRd, vecs[v].expErr, 1'b0, $sformatf("vec%0d", v));
        end

        // addr0 moves 4 -> 9 after acceptance; the latched command must win
        doTxn(0, 1'b0, 8'd4, 8'h00, 8'h44, 1'b0, 1'b1, "addr change");
        check("addr change mem9 untouched", mem[9], 8'h49);

        // Both ports request together right after reset: 0,1,0,1 every 3 cycles
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drivePort(0, 1'b1, 1'b0, 8'd1, 8'h00);
        drivePort(1, 1'b1, 1'b0, 8'd2, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("both gnt cyc%0d", k), gnt0 & gnt1, 0);
            if (gnt0 || gnt1) begin
                gCycle.push_back(k);
                gId.push_back(gnt1 ? 1 : 0);
            end
        end
        drivePort(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drivePort(1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("alt grant count", gId.size(), 4);
        for (int g = 0; g < 4 && g < gId.size(); g++) begin
            check($sformatf("alt grant%0d id", g), gId[g], g % 2);
            check($sformatf("alt grant%0d cycle", g), gCycle[g], 1 + 3 * g);
        end
        repeat (3) @(negedge clk);
        check("idle at end", dbgState, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
